// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the keypad/graph side and the breakout game sequencer.
// The master modport belongs to the side that produces keypad and graph events.
interface breakout_game_ctrl_if;
  logic        key_ready;
  logic [4:0]  key_code;
  logic        hit;
  logic        miss;
  logic        all_clear;
  logic [1:0]  state;
  logic        gra_still;
  logic        ball_reset;
  logic [2:0]  balls_left;
  logic [15:0] score;
  logic        win;
  logic        busy;

  modport master (
    output key_ready, key_code, hit, miss, all_clear,
    input  state, gra_still, ball_reset, balls_left, score, win, busy
  );

  modport slave (
    input  key_ready, key_code, hit, miss, all_clear,
    output state, gra_still, ball_reset, balls_left, score, win, busy
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: run/freeze control, ball serving, lives and BCD score.
// All outputs are registered and reflect the new state on the transition edge.
module breakout_game_ctrl #(
  parameter int unsigned          LIVES     = 3,
  parameter logic [4:0]           START_KEY = 5'h10,
  parameter int unsigned          DELAY_W   = 28,
  parameter logic [DELAY_W-1:0]   DELAY     = DELAY_W'(200_000_000)
) (
  input  logic                  clk,
  input  logic                  rstn,
  breakout_game_ctrl_if.slave   bus
);
  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam logic [2:0] C_LIVES = 3'(LIVES);

  logic [1:0]         r_state;
  logic               r_still;
  logic               r_ball_reset;
  logic [2:0]         r_balls;
  logic [15:0]        r_score;
  logic               r_win;
  logic               r_busy;
  logic [DELAY_W-1:0] r_timer;
  logic               r_key_prev;

  logic               w_start_evt;
  logic [1:0]         w_state_nxt;
  logic               w_still_nxt;
  logic               w_ball_reset_nxt;
  logic [2:0]         w_balls_nxt;
  logic [15:0]        w_score_nxt;
  logic               w_win_nxt;
  logic [DELAY_W-1:0] w_timer_nxt;

  // Four-digit BCD increment with ripple carry, saturating at 9999.
  function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = '0;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_start_evt = bus.key_ready & ~r_key_prev & (bus.key_code == START_KEY);

  always_comb begin
    w_state_nxt      = r_state;
    w_still_nxt      = r_still;
    w_ball_reset_nxt = 1'b0;
    w_balls_nxt      = r_balls;
    w_score_nxt      = r_score;
    w_win_nxt        = r_win;
    w_timer_nxt      = r_timer;
    case (r_state)
      ST_NEWGAME: begin
        w_still_nxt = 1'b1;
        if (w_start_evt) begin
          w_state_nxt = ST_PLAY;
          w_still_nxt = 1'b0;
        end
      end
      ST_PLAY: begin
        w_still_nxt = 1'b0;
        if (bus.hit) w_score_nxt = f_bcd_inc(r_score);
        // all_clear outranks a same-cycle miss: lives stay untouched on a win
        if (bus.all_clear) begin
          w_state_nxt = ST_OVER;
          w_win_nxt   = 1'b1;
          w_timer_nxt = DELAY;
          w_still_nxt = 1'b1;
        end else if (bus.miss) begin
          w_timer_nxt = DELAY;
          w_still_nxt = 1'b1;
          if (r_balls == 3'd1) begin
            w_state_nxt = ST_OVER;
            w_balls_nxt = '0;
            w_win_nxt   = 1'b0;
          end else begin
            w_state_nxt      = ST_NEWBALL;
            w_balls_nxt      = r_balls - 3'd1;
            w_ball_reset_nxt = 1'b1;
          end
        end
      end
      ST_NEWBALL: begin
        w_still_nxt = 1'b1;
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - DELAY_W'(1);
        end else if (w_start_evt) begin
          w_state_nxt = ST_PLAY;
          w_still_nxt = 1'b0;
        end
      end
      default: begin
        w_still_nxt = 1'b1;
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - DELAY_W'(1);
        end else if (w_start_evt) begin
          w_state_nxt      = ST_NEWGAME;
          w_score_nxt      = '0;
          w_balls_nxt      = C_LIVES;
          w_win_nxt        = 1'b0;
          w_ball_reset_nxt = 1'b1;
        end
      end
    endcase
  end

  // key_prev resets high so a key held through reset is not taken as a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_NEWGAME;
      r_still      <= 1'b1;
      r_ball_reset <= 1'b0;
      r_balls      <= C_LIVES;
      r_score      <= '0;
      r_win        <= 1'b0;
      r_busy       <= 1'b0;
      r_timer      <= '0;
      r_key_prev   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_still      <= w_still_nxt;
      r_ball_reset <= w_ball_reset_nxt;
      r_balls      <= w_balls_nxt;
      r_score      <= w_score_nxt;
      r_win        <= w_win_nxt;
      r_busy       <= (w_timer_nxt != '0);
      r_timer      <= w_timer_nxt;
      r_key_prev   <= bus.key_ready;
    end
  end

  assign bus.state      = r_state;
  assign bus.gra_still  = r_still;
  assign bus.ball_reset = r_ball_reset;
  assign bus.balls_left = r_balls;
  assign bus.score      = r_score;
  assign bus.win        = r_win;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl with DELAY=4, LIVES=3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_breakout_game_ctrl;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  breakout_game_ctrl_if bif ();

  breakout_game_ctrl #(
    .LIVES     (3),
    .START_KEY (5'h10),
    .DELAY_W   (28),
    .DELAY     (28'd4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input logic [4:0] code);
    bif.key_code  = code;
    bif.key_ready = 1'b1;
    cyc();
  endtask

  task automatic release_key();
    bif.key_ready = 1'b0;
    cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  32'(bif.state),      32'h0);
    check({tag, "_still"},  32'(bif.gra_still),  32'h1);
    check({tag, "_brst"},   32'(bif.ball_reset), 32'h0);
    check({tag, "_balls"},  32'(bif.balls_left), 32'h3);
    check({tag, "_score"},  32'(bif.score),      32'h0);
    check({tag, "_win"},    32'(bif.win),        32'h0);
    check({tag, "_busy"},   32'(bif.busy),       32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rstn          = 1'b0;
    bif.key_ready = 1'b0;
    bif.key_code  = 5'h00;
    bif.hit       = 1'b0;
    bif.miss      = 1'b0;
    bif.all_clear = 1'b0;
    #12;
    check_reset_vals("rst");
    cyc();
    rstn = 1'b1;
    cyc();

    press(5'h0c);
    check("wrong_key_state", 32'(bif.state), 32'h0);
    check("wrong_key_still", 32'(bif.gra_still), 32'h1);
    release_key();

    press(5'h10);
    check("start_state", 32'(bif.state), 32'h1);
    check("start_still", 32'(bif.gra_still), 32'h0);
    check("start_balls", 32'(bif.balls_left), 32'h3);
    release_key();

    bif.hit = 1'b1;
    cycs(1000);
    check("score_1000", 32'(bif.score), 32'h1000);
    cycs(8998);
    bif.hit = 1'b0;
    cyc();
    check("score_9998", 32'(bif.score), 32'h9998);
    bif.hit = 1'b1;
    cyc();
    check("score_9999", 32'(bif.score), 32'h9999);
    cyc();
    check("score_sat", 32'(bif.score), 32'h9999);
    bif.hit = 1'b0;

    bif.miss = 1'b1;
    cyc();
    bif.miss = 1'b0;
    check("miss1_state", 32'(bif.state), 32'h2);
    check("miss1_balls", 32'(bif.balls_left), 32'h2);
    check("miss1_brst",  32'(bif.ball_reset), 32'h1);
    check("miss1_busy0", 32'(bif.busy), 32'h1);
    check("miss1_still", 32'(bif.gra_still), 32'h1);
    bif.key_code  = 5'h10;
    bif.key_ready = 1'b1;
    cyc();
    check("miss1_brst_off", 32'(bif.ball_reset), 32'h0);
    check("miss1_busy1", 32'(bif.busy), 32'h1);
    cyc();
    check("early_start_state", 32'(bif.state), 32'h2);
    check("miss1_busy2", 32'(bif.busy), 32'h1);
    bif.key_ready = 1'b0;
    cyc();
    check("miss1_busy3", 32'(bif.busy), 32'h1);
    cyc();
    check("miss1_busy4", 32'(bif.busy), 32'h0);
    check("miss1_still_nb", 32'(bif.state), 32'h2);
    press(5'h10);
    check("serve_state", 32'(bif.state), 32'h1);
    check("serve_still", 32'(bif.gra_still), 32'h0);
    release_key();

    bif.miss = 1'b1;
    cyc();
    bif.miss = 1'b0;
    check("miss2_balls", 32'(bif.balls_left), 32'h1);
    cycs(4);
    press(5'h10);
    check("serve2_state", 32'(bif.state), 32'h1);
    release_key();

    bif.miss = 1'b1;
    cyc();
    bif.miss = 1'b0;
    check("miss3_state", 32'(bif.state), 32'h3);
    check("miss3_balls", 32'(bif.balls_left), 32'h0);
    check("miss3_win",   32'(bif.win), 32'h0);
    check("miss3_brst",  32'(bif.ball_reset), 32'h0);
    check("miss3_score", 32'(bif.score), 32'h9999);
    cycs(4);
    check("over_busy_done", 32'(bif.busy), 32'h0);
    press(5'h10);
    check("regame_state", 32'(bif.state), 32'h0);
    check("regame_score", 32'(bif.score), 32'h0);
    check("regame_balls", 32'(bif.balls_left), 32'h3);
    check("regame_brst",  32'(bif.ball_reset), 32'h1);
    release_key();
    check("regame_brst_off", 32'(bif.ball_reset), 32'h0);

    press(5'h10);
    check("g2_state", 32'(bif.state), 32'h1);
    release_key();
    bif.hit       = 1'b1;
    bif.miss      = 1'b1;
    bif.all_clear = 1'b1;
    cyc();
    bif.hit       = 1'b0;
    bif.miss      = 1'b0;
    bif.all_clear = 1'b0;
    check("combo_score", 32'(bif.score), 32'h0001);
    check("combo_state", 32'(bif.state), 32'h3);
    check("combo_win",   32'(bif.win), 32'h1);
    check("combo_balls", 32'(bif.balls_left), 32'h3);
    check("combo_busy",  32'(bif.busy), 32'h1);

    bif.key_code  = 5'h10;
    bif.key_ready = 1'b1;
    rstn = 1'b0;
    #1;
    check_reset_vals("rst2");
    cyc();
    rstn = 1'b1;
    cyc();
    check("held_key_state0", 32'(bif.state), 32'h0);
    cyc();
    check("held_key_state1", 32'(bif.state), 32'h0);
    release_key();
    press(5'h10);
    check("fresh_press_state", 32'(bif.state), 32'h1);
    release_key();

    bif.hit = 1'b1;
    cyc();
    bif.hit  = 1'b0;
    bif.miss = 1'b1;
    cyc();
    bif.miss = 1'b0;
    check("nb_state", 32'(bif.state), 32'h2);
    check("nb_brst",  32'(bif.ball_reset), 32'h1);
    check("nb_score", 32'(bif.score), 32'h0001);
    rstn = 1'b0;
    #1;
    check_reset_vals("rst3");
    cyc();
    rstn = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
